// File: rtl/pu_select_if.sv
// Bus bundle for the conditional-select PU: write/enable strobes, argument
// word with attributes, mode select, and the registered result lanes.
interface pu_select_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SEL_WIDTH  = 3
) ();
    logic                  wr;
    logic                  oe;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ATTR_WIDTH-1:0] attr_in;
    logic [SEL_WIDTH-1:0]  op_sel;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ATTR_WIDTH-1:0] attr_out;

    modport master (
        output wr, oe, data_in, attr_in, op_sel,
        input  data_out, attr_out
    );

    modport slave (
        input  wr, oe, data_in, attr_in, op_sel,
        output data_out, attr_out
    );
endinterface

// File: rtl/pu_select.sv
// Conditional-select PU: gathers condition, A and B over three bus writes,
// then yields cond ? A : B (or the inverse) with invalid-flag propagation.
module pu_select #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SEL_WIDTH  = 3
) (
    input  logic          clk,
    input  logic          rst,
    pu_select_if.slave    bus
);

    typedef enum logic [1:0] {
        WAIT_COND = 2'd0,
        WAIT_A    = 2'd1,
        WAIT_B    = 2'd2,
        COMPUTE   = 2'd3
    } state_t;

    localparam logic [SEL_WIDTH-1:0] MODE_SELN = SEL_WIDTH'(1);

    // Any nonzero word counts as true, including all-ones.
    function automatic logic word_is_true(input logic [DATA_WIDTH-1:0] w);
        return (w != {DATA_WIDTH{1'b0}});
    endfunction

    state_t                state_q, state_d;
    logic                  cond_true_q, cond_true_d;
    logic                  cond_inv_q, cond_inv_d;
    logic                  mode_inv_q, mode_inv_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [ATTR_WIDTH-1:0] a_attr_q, a_attr_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [ATTR_WIDTH-1:0] b_attr_q, b_attr_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [ATTR_WIDTH-1:0] result_attr_q, result_attr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [ATTR_WIDTH-1:0] attr_out_q, attr_out_d;

    logic                  load_cond_s;
    logic                  load_a_s;
    logic                  load_b_s;
    logic                  load_result_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_COND;
            cond_true_q   <= 1'b0;
            cond_inv_q    <= 1'b0;
            mode_inv_q    <= 1'b0;
            a_q           <= {DATA_WIDTH{1'b0}};
            a_attr_q      <= {ATTR_WIDTH{1'b0}};
            b_q           <= {DATA_WIDTH{1'b0}};
            b_attr_q      <= {ATTR_WIDTH{1'b0}};
            result_q      <= {DATA_WIDTH{1'b0}};
            result_attr_q <= {ATTR_WIDTH{1'b0}};
            data_out_q    <= {DATA_WIDTH{1'b0}};
            attr_out_q    <= {ATTR_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            cond_true_q   <= cond_true_d;
            cond_inv_q    <= cond_inv_d;
            mode_inv_q    <= mode_inv_d;
            a_q           <= a_d;
            a_attr_q      <= a_attr_d;
            b_q           <= b_d;
            b_attr_q      <= b_attr_d;
            result_q      <= result_d;
            result_attr_q <= result_attr_d;
            data_out_q    <= data_out_d;
            attr_out_q    <= attr_out_d;
        end
    end

    // Next-state logic; a write during COMPUTE starts the next sequence at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_COND: begin
                if (bus.wr) begin
                    state_d = WAIT_A;
                end else begin
                    state_d = WAIT_COND;
                end
            end
            WAIT_A: begin
                if (bus.wr) begin
                    state_d = WAIT_B;
                end else begin
                    state_d = WAIT_A;
                end
            end
            WAIT_B: begin
                if (bus.wr) begin
                    state_d = COMPUTE;
                end else begin
                    state_d = WAIT_B;
                end
            end
            COMPUTE: begin
                if (bus.wr) begin
                    state_d = WAIT_A;
                end else begin
                    state_d = WAIT_COND;
                end
            end
            default: begin
                state_d = WAIT_COND;
            end
        endcase
    end

    // Per-state load strobes for the argument and result registers.
    always_comb begin
        load_cond_s   = 1'b0;
        load_a_s      = 1'b0;
        load_b_s      = 1'b0;
        load_result_s = 1'b0;
        case (state_q)
            WAIT_COND: load_cond_s = bus.wr;
            WAIT_A:    load_a_s    = bus.wr;
            WAIT_B:    load_b_s    = bus.wr;
            COMPUTE: begin
                load_result_s = 1'b1;
                load_cond_s   = bus.wr;
            end
            default: begin
                load_cond_s   = 1'b0;
                load_a_s      = 1'b0;
                load_b_s      = 1'b0;
                load_result_s = 1'b0;
            end
        endcase
    end

    // Argument capture; op_sel matters only alongside the condition word.
    always_comb begin
        cond_true_d = cond_true_q;
        cond_inv_d  = cond_inv_q;
        mode_inv_d  = mode_inv_q;
        a_d         = a_q;
        a_attr_d    = a_attr_q;
        b_d         = b_q;
        b_attr_d    = b_attr_q;
        if (load_cond_s) begin
            cond_true_d = word_is_true(bus.data_in);
            cond_inv_d  = bus.attr_in[0];
            mode_inv_d  = (bus.op_sel == MODE_SELN);
        end else begin
            cond_true_d = cond_true_q;
        end
        if (load_a_s) begin
            a_d      = bus.data_in;
            a_attr_d = bus.attr_in;
        end else begin
            a_d      = a_q;
        end
        if (load_b_s) begin
            b_d      = bus.data_in;
            b_attr_d = bus.attr_in;
        end else begin
            b_d      = b_q;
        end
    end

    // Select from the registered operands; an invalid condition taints the result.
    always_comb begin
        result_d      = result_q;
        result_attr_d = result_attr_q;
        if (load_result_s) begin
            if (cond_true_q ^ mode_inv_q) begin
                result_d      = a_q;
                result_attr_d = a_attr_q;
            end else begin
                result_d      = b_q;
                result_attr_d = b_attr_q;
            end
            result_attr_d[0] = result_attr_d[0] | cond_inv_q;
        end else begin
            result_d      = result_q;
            result_attr_d = result_attr_q;
        end
    end

    // Output lanes are zero whenever the enable was low at the sampling edge.
    always_comb begin
        data_out_d = {DATA_WIDTH{1'b0}};
        attr_out_d = {ATTR_WIDTH{1'b0}};
        if (bus.oe) begin
            data_out_d = result_q;
            attr_out_d = result_attr_q;
        end else begin
            data_out_d = {DATA_WIDTH{1'b0}};
            attr_out_d = {ATTR_WIDTH{1'b0}};
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.attr_out = attr_out_q;

endmodule
